fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Upstream neighbour of the instruction buffer. Generates sequential fetch addresses and issues them over a request/grant instruction-memory port.
- Collects in-order read responses into a 2-entry skid queue and pushes them into the buffer as 30-bit instruction words (bits [31:2]) with their addresses.
- Handles pipeline redirects (branch/jump/trap) by flushing the buffer, discarding stale responses and restarting from the new PC.

Parameters:
- XLEN, 32, GPR/address width (32 or 64).
- RESET_ADDR, 0, first fetch address after reset; must be 4-byte aligned.
- MAX_INFLIGHT, 2, cap on granted-but-unanswered requests plus skid occupancy; fixed at 2, matching skid depth.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- halt  in  1  stop issuing new requests; in-flight responses still complete.
- redirect  in  1  one-cycle pulse: restart fetch at redirectAddr.
- redirectAddr  in  XLEN  new PC; bits [1:0] ignored (forced 0).
- bufferFull  in  1  instruction buffer full flag.
- bufferFlush  out  1  drives buffer flush; equals redirect combinationally.
- iMemReq  out  1  fetch request valid.
- iMemAddr  out  XLEN  fetch address, [1:0]=0.
- iMemGnt  in  1  request accepted this cycle.
- iMemRvalid  in  1  response valid; responses are in order, earliest one cycle after grant.
- iMemRdata  in  32  response instruction word.
- push  out  1  push to buffer.
- instrOut  out  30  instruction bits [31:2].
- iAddrOut  out  XLEN  address of instrOut.

Behaviour:
- **Reset:**
  - PC = RESET_ADDR; inflight = 0; drop = 0; skid empty; state = BOOT.
  - iMemReq = 0, push = 0, instrOut = 0, iAddrOut = 0.
  - Reset mid-operation discards everything; later responses to pre-reset grants are the environment's problem (the memory is reset with the core).
- **State machine:**
  - BOOT goes to RUN after one cycle.
  - RUN goes to HALTED when halt=1.
  - HALTED goes back to RUN when halt=0.
  - redirect is honoured in every state; it does not change the state, except BOOT, which moves to RUN.
- **Request issue:**
  - iMemReq = (state==RUN) && !redirect && (inflight + skidCount < 2). iMemAddr = PC.
  - On iMemReq && iMemGnt: PC += 4, inflight += 1.
  - While req=1 and gnt=0, the address is held stable unless a redirect occurs.
  - halt drops req the same cycle.
- **Response:**
  - On iMemRvalid: inflight -= 1.
  - If drop > 0: drop -= 1 and the data is discarded.
  - Otherwise enqueue {iMemRdata[31:2], addr} into the skid. addr comes from a per-slot address record captured at grant time.
  - The capacity rule guarantees the skid never overflows.
- **Push:**
  - push = skid non-empty && !bufferFull && !redirect. instrOut/iAddrOut = skid head.
  - push dequeues the head.
  - An enqueue and a dequeue in the same cycle are both honoured; entry order is preserved.
  - With an empty skid and an arriving response, push is at the earliest the next cycle (registered skid, 1-cycle response-to-push latency).
- **Redirect (cycle T):**
  - bufferFlush = 1, push = 0, iMemReq = 0.
  - Skid cleared.
  - PC = {redirectAddr[XLEN-1:2], 2'b00}.
  - drop = drop + inflight + (gnt&&req ? 1 : 0) − (rvalid ? 1 : 0), saturated to inflight_next. inflight keeps its arithmetic.
  - A response arriving at T is discarded.
  - First new request at T+1 (if RUN and capacity allows).
- **Back-to-back redirects:** the last one wins; drop accumulates correctly.
- **Widths/wrap:** PC wraps modulo 2^XLEN; inflight and drop are 2 bits, and must never exceed 2 (assert).
- Instruction low bits [1:0] are not checked here; decode handles them.

Decomposition:
- Shared package (core_pkg): XLEN default, RESET_ADDR, NOP encoding, fetch state enum {BOOT, RUN, HALTED}.
- One natural sub-module: fetch_skid_fifo (2-entry, data 30 + XLEN, push/pop/clear, count output).
- PC, inflight/drop counters and FSM stay in fetch_unit.

Test Plan:
- **Reset/boot:** reset high 3 cycles, gnt=1, 1-cycle memory -> req first high cycle 2 after reset release, addr 0x0, then 0x4, 0x8; pushes of instrOut = rdata[31:2] in address order.
- **Backpressure:** bufferFull=1 from cycle 5 -> at most 2 responses held, req low while inflight+skid = 2, no push. Release -> pushes resume, addresses contiguous, none lost or duplicated.
- **Redirect with 2 in flight:** grants at 0x10 and 0x14 unanswered, redirect to 0x103 -> bufferFlush pulse. The next 2 responses are dropped, next req addr 0x100, first push iAddrOut = 0x100.
- **Redirect coincident with rvalid and gnt:** drop counts exactly the stale grants; only post-redirect data is pushed.
- **Grant stall:** gnt=0 for 4 cycles -> iMemAddr stable, PC not advanced. Redirect during the stall -> new addr next cycle.
- **Halt:** halt at cycle 10 with 1 in flight -> req low, the pending response still pushed, no further requests until halt=0; then resume at the next sequential PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch constants, state enum and helpers
package fetch_unit_pkg;

    localparam int          XLEN_DEFAULT       = 32;
    localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;
    localparam int          SKID_DEPTH         = 2;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetchState_t;

    // The buffer stores only the upper 30 bits; decode owns the low pair.
    function automatic logic [29:0] instrBits(input logic [31:0] word);
        return word[31:2];
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/grant/response port
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) ();

    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [31:0]     rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/fetch_unit_skid_fifo.sv
// rtl/fetch_unit_skid_fifo.sv - 2-entry registered skid queue with clear
module fetch_skid_fifo #(
    parameter int WIDTH = 62
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             wrEn,
    input  logic [WIDTH-1:0] wrData,
    input  logic             rdEn,
    output logic [WIDTH-1:0] rdData,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wrPtr;
    logic             rdPtr;

    assign rdData = mem[rdPtr];

    always_ff @(posedge clock) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wrPtr  <= 1'b0;
            rdPtr  <= 1'b0;
            count  <= 2'd0;
        end else if (clear) begin
            wrPtr <= 1'b0;
            rdPtr <= 1'b0;
            count <= 2'd0;
        end else begin
            if (wrEn) begin
                mem[wrPtr] <= wrData;
                wrPtr      <= ~wrPtr;
            end
            if (rdEn) begin
                rdPtr <= ~rdPtr;
            end
            count <= count + {1'b0, wrEn} - {1'b0, rdEn};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - sequential fetch address generator with redirect and skid
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_ADDR   = XLEN'(RESET_ADDR_DEFAULT),
    parameter int              MAX_INFLIGHT = SKID_DEPTH
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            halt,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirectAddr,
    input  logic            bufferFull,
    output logic            bufferFlush,
    fetch_unit_if.master    iMem,
    output logic            push,
    output logic [29:0]     instrOut,
    output logic [XLEN-1:0] iAddrOut
);

    fetchState_t     state;
    logic [XLEN-1:0] pc;
    logic [1:0]      inflight;
    logic [1:0]      drop;
    logic [1:0]      dropNext;
    logic [2:0]      dropSum;
    logic [2:0]      inflightNext;
    logic [2:0]      occupancy;
    logic [1:0]      skidCount;
    logic            issue;
    logic            keep;
    logic [XLEN-1:0] addrRec [2];
    logic            recWr;
    logic            recRd;
    logic [29+XLEN:0] skidHead;
    logic            unusedAddrBits;

    assign unusedAddrBits = ^redirectAddr[1:0];

    assign occupancy    = {1'b0, inflight} + {1'b0, skidCount};
    assign iMem.req     = (state == RUN) && !halt && !redirect && (occupancy < 3'(MAX_INFLIGHT));
    assign iMem.addr    = pc;
    assign issue        = iMem.req && iMem.gnt;
    assign inflightNext = {1'b0, inflight} + {2'b0, issue} - {2'b0, iMem.rvalid};

    assign bufferFlush = redirect;
    assign keep        = iMem.rvalid && (drop == 2'd0) && !redirect;
    assign push        = (skidCount != 2'd0) && !bufferFull && !redirect;
    assign instrOut    = skidHead[29+XLEN:XLEN];
    assign iAddrOut    = skidHead[XLEN-1:0];

    // Every grant still outstanding at a redirect is stale and must be swallowed.
    always_comb begin
        dropSum  = {1'b0, drop} + {1'b0, inflight} + {2'b0, issue} - {2'b0, iMem.rvalid};
        dropNext = drop;
        if (redirect) begin
            dropNext = (dropSum > inflightNext) ? inflightNext[1:0] : dropSum[1:0];
        end else if (iMem.rvalid && (drop != 2'd0)) begin
            dropNext = drop - 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= BOOT;
            pc       <= RESET_ADDR;
            inflight <= 2'd0;
            drop     <= 2'd0;
            recWr    <= 1'b0;
            recRd    <= 1'b0;
        end else begin
            case (state)
                BOOT:    state <= RUN;
                RUN:     if (halt) state <= HALTED;
                HALTED:  if (!halt) state <= RUN;
                default: state <= BOOT;
            endcase
            if (issue) begin
                addrRec[recWr] <= pc;
                recWr          <= ~recWr;
            end
            if (iMem.rvalid) begin
                recRd <= ~recRd;
            end
            if (redirect) begin
                pc <= {redirectAddr[XLEN-1:2], 2'b00};
            end else if (issue) begin
                pc <= pc + XLEN'(4);
            end
            inflight <= inflightNext[1:0];
            drop     <= dropNext;
        end
    end

    fetch_skid_fifo #(
        .WIDTH(30 + XLEN)
    ) skid (
        .clock  (clock),
        .reset  (reset),
        .clear  (redirect),
        .wrEn   (keep),
        .wrData ({instrBits(iMem.rdata), addrRec[recRd]}),
        .rdEn   (push),
        .rdData (skidHead),
        .count  (skidCount)
    );

    assert property (@(posedge clock) disable iff (reset) (inflight <= 2'd2) && (drop <= inflight));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit with transaction-level model
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        halt;
    logic        redirect;
    logic [31:0] redirectAddr;
    logic        bufferFull;
    logic        bufferFlush;
    logic        push;
    logic [29:0] instrOut;
    logic [31:0] iAddrOut;

    fetch_unit_if #(.XLEN(32)) iMem ();

    fetch_unit #(
        .XLEN       (32),
        .RESET_ADDR (32'h0)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .halt         (halt),
        .redirect     (redirect),
        .redirectAddr (redirectAddr),
        .bufferFull   (bufferFull),
        .bufferFlush  (bufferFlush),
        .iMem         (iMem),
        .push         (push),
        .instrOut     (instrOut),
        .iAddrOut     (iAddrOut)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } grant_t;

    grant_t      pending[$];
    logic [31:0] skidQ[$];
    logic [31:0] modelPc;
    int          epoch;
    bit          booted;
    bit          haltedSt;
    int          checks;
    int          failures;
    bit          armFirst;
    logic [31:0] firstPush;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic doReset(input int n);
        reset        = 1'b1;
        halt         = 1'b0;
        redirect     = 1'b0;
        redirectAddr = '0;
        bufferFull   = 1'b0;
        iMem.gnt     = 1'b0;
        iMem.rvalid  = 1'b0;
        iMem.rdata   = '0;
        repeat (n) @(posedge clock);
        #1;
        checkValue("rst_req", iMem.req, 0);
        checkValue("rst_push", push, 0);
        checkValue("rst_instr", instrOut, 0);
        checkValue("rst_iaddr", iAddrOut, 0);
        reset = 1'b0;
        pending.delete();
        skidQ.delete();
        modelPc  = 32'h0;
        booted   = 1'b0;
        haltedSt = 1'b0;
        epoch++;
    endtask

    // One clock cycle: drive, check against the model at negedge, advance model at posedge.
    task automatic step(input bit h, input bit rd, input logic [31:0] ra, input bit full,
                        input int gntPct, input int rvPct);
        bit          expReq;
        bit          expPush;
        bit          sGnt;
        bit          sRv;
        logic [31:0] word;
        grant_t      g;
        halt         = h;
        redirect     = rd;
        redirectAddr = ra;
        bufferFull   = full;
        iMem.gnt     = (int'($urandom_range(99)) < gntPct);
        if (pending.size() > 0 && int'($urandom_range(99)) < rvPct) begin
            iMem.rvalid = 1'b1;
            iMem.rdata  = memWord(pending[0].addr);
        end else begin
            iMem.rvalid = 1'b0;
            iMem.rdata  = $urandom;
        end
        @(negedge clock);
        expReq  = booted && !haltedSt && !h && !rd && (pending.size() + skidQ.size() < 2);
        expPush = (skidQ.size() > 0) && !full && !rd;
        checkValue("req", iMem.req, expReq);
        if (expReq && iMem.req) checkValue("addr", iMem.addr, modelPc);
        checkValue("flush", bufferFlush, rd);
        checkValue("push", push, expPush);
        if (expPush && push) begin
            word = memWord(skidQ[0]);
            checkValue("iaddr", iAddrOut, skidQ[0]);
            checkValue("instr", instrOut, word[31:2]);
            if (armFirst) begin
                firstPush = iAddrOut;
                armFirst  = 1'b0;
            end
        end
        sGnt = iMem.gnt;
        sRv  = iMem.rvalid;
        @(posedge clock);
        if (expPush) void'(skidQ.pop_front());
        if (sRv) begin
            g = pending.pop_front();
            if (g.epoch == epoch && !rd) skidQ.push_back(g.addr);
        end
        if (rd) begin
            skidQ.delete();
            epoch++;
            modelPc = {ra[31:2], 2'b00};
        end else if (expReq && sGnt) begin
            pending.push_back('{addr: modelPc, epoch: epoch});
            modelPc = modelPc + 32'd4;
        end
        if (!booted) begin
            booted   = 1'b1;
            haltedSt = 1'b0;
        end else begin
            haltedSt = h;
        end
        #1;
    endtask

    initial begin
        int          guard;
        bit          haltLvl;
        logic [31:0] ra;
        checks   = 0;
        failures = 0;
        epoch    = 0;
        armFirst = 1'b0;
        firstPush = '0;
        doReset(3);

        // boot with an always-granting, 1-cycle memory
        repeat (10) step(0, 0, 0, 0, 100, 100);

        // backpressure then release
        repeat (12) step(0, 0, 0, 1, 100, 100);
        repeat (10) step(0, 0, 0, 0, 100, 100);

        // move to 0x10 and build two unanswered grants, then redirect to 0x103
        step(0, 1, 32'h10, 0, 0, 0);
        guard = 0;
        while (pending.size() < 2 && guard < 10) begin
            step(0, 0, 0, 0, 100, 0);
            guard++;
        end
        checkValue("setup_inflight", pending.size(), 2);
        step(0, 1, 32'h103, 0, 100, 0);
        armFirst = 1'b1;
        repeat (10) step(0, 0, 0, 0, 100, 100);
        checkValue("redir_first_push", firstPush, 32'h100);

        // redirect coinciding with a response and a grant
        repeat (2) step(0, 0, 0, 0, 100, 0);
        step(0, 1, 32'h2000, 0, 100, 100);
        armFirst = 1'b1;
        repeat (10) step(0, 0, 0, 0, 100, 100);
        checkValue("coinc_first_push", firstPush, 32'h2000);

        // grant stall, then redirect during the stall
        repeat (4) step(0, 0, 0, 0, 0, 100);
        step(0, 1, 32'h3008, 0, 0, 0);
        repeat (8) step(0, 0, 0, 0, 100, 100);

        // halt with a response in flight
        step(0, 0, 0, 0, 100, 0);
        repeat (6) step(1, 0, 0, 0, 100, 100);
        repeat (8) step(0, 0, 0, 0, 100, 100);

        // randomized traffic, including redirects near the top of the address space
        haltLvl = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 4) haltLvl = ~haltLvl;
            ra = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            step(haltLvl, ($urandom_range(99) < 6), ra, ($urandom_range(3) == 0),
                 int'($urandom_range(100)), int'($urandom_range(100)));
        end

        // reset in the middle of traffic
        doReset(2);
        for (int i = 0; i < 40; i++) begin
            step(0, ($urandom_range(99) < 5), $urandom, ($urandom_range(3) == 0), 70, 60);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

endmodule
